// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, one consumer and alu_arbiter.
interface alu_arbiter_if #(
    parameter int VAR_WIDTH = 32,
    parameter int OP_WIDTH  = 4
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [OP_WIDTH-1:0]  req0_opcode;
    logic [VAR_WIDTH-1:0] req0_a;
    logic [VAR_WIDTH-1:0] req0_b;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [OP_WIDTH-1:0]  req1_opcode;
    logic [VAR_WIDTH-1:0] req1_a;
    logic [VAR_WIDTH-1:0] req1_b;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [VAR_WIDTH-1:0] rsp_data;

    logic                 busy;

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Combinational ALU shared round-robin between two requesters, with registered
// operands and a registered result.
//
// Opcode encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
// 8 SLT, 9 SLTU; every other code yields 0.

module alu #(
    parameter int VAR_WIDTH = 32,
    parameter int OP_WIDTH  = 4
) (
    input  logic [OP_WIDTH-1:0]  opcode,
    input  logic [VAR_WIDTH-1:0] a,
    input  logic [VAR_WIDTH-1:0] b,
    output logic [VAR_WIDTH-1:0] out
);
    localparam int SHW = $clog2(VAR_WIDTH);

    localparam logic [OP_WIDTH-1:0] ALUADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] ALUSUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] ALUAND  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] ALUOR   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] ALUXOR  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] ALUSLL  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] ALUSRL  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] ALUSRA  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] ALUSLT  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] ALUSLTU = OP_WIDTH'(9);

    // result select; undefined opcodes fall through to zero
    always_comb begin
        out = '0;
        case (opcode)
            ALUADD:  out = a + b;
            ALUSUB:  out = a - b;
            ALUAND:  out = a & b;
            ALUOR:   out = a | b;
            ALUXOR:  out = a ^ b;
            ALUSLL:  out = a << b[SHW-1:0];
            ALUSRL:  out = a >> b[SHW-1:0];
            ALUSRA:  out = $signed(a) >>> b[SHW-1:0];
            ALUSLT:  out = {{(VAR_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUSLTU: out = {{(VAR_WIDTH-1){1'b0}}, (a < b)};
            default: out = '0;
        endcase
    end
endmodule

// state | meaning
// IDLE  | waiting for a request; grant offered to one requester
// EXEC  | ALU evaluates the captured operands; result registered at end
// RESP  | result held on rsp_* until the consumer takes it
module alu_arbiter #(
    parameter int VAR_WIDTH = 32,
    parameter int OP_WIDTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [OP_WIDTH-1:0]  OP_SLL     = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0]  OP_SRL     = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0]  OP_SRA     = OP_WIDTH'(7);
    localparam logic [VAR_WIDTH-1:0] SHAMT_MASK = VAR_WIDTH'(VAR_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state_q, state_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [OP_WIDTH-1:0]  op_q, op_d;
    logic [VAR_WIDTH-1:0] a_q, a_d;
    logic [VAR_WIDTH-1:0] b_q, b_d;
    logic                 id_q, id_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [VAR_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                 gnt_vld;
    logic                 gnt_id;
    logic [OP_WIDTH-1:0]  sel_op;
    logic [VAR_WIDTH-1:0] sel_a;
    logic [VAR_WIDTH-1:0] sel_b;
    logic [VAR_WIDTH-1:0] alu_out;

    alu #(
        .VAR_WIDTH(VAR_WIDTH),
        .OP_WIDTH (OP_WIDTH)
    ) u_alu (
        .opcode(op_q),
        .a     (a_q),
        .b     (b_q),
        .out   (alu_out)
    );

    // round-robin grant: the pointed-to requester first, else the other one
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = rr_ptr_q;
        if (rr_ptr_q ? bus.req1_valid : bus.req0_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = rr_ptr_q;
        end else if (rr_ptr_q ? bus.req0_valid : bus.req1_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = ~rr_ptr_q;
        end
        sel_op = gnt_id ? bus.req1_opcode : bus.req0_opcode;
        sel_a  = gnt_id ? bus.req1_a      : bus.req0_a;
        sel_b  = gnt_id ? bus.req1_b      : bus.req0_b;
    end

    // ready is only ever offered to the granted requester, and never in reset
    assign bus.req0_ready = !rst && (state_q == IDLE) && gnt_vld && !gnt_id;
    assign bus.req1_ready = !rst && (state_q == IDLE) && gnt_vld &&  gnt_id;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = (state_q != IDLE);

    // next-state and datapath capture
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    op_d    = sel_op;
                    a_d     = sel_a;
                    // shifts only ever see a legal shift amount
                    b_d     = (sel_op == OP_SLL || sel_op == OP_SRL || sel_op == OP_SRA)
                              ? (sel_b & SHAMT_MASK) : sel_b;
                    id_d    = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = ~rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural model of arbitration and ALU arithmetic.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    // pending request per requester and the model's round-robin pointer
    logic        v   [2];
    logic [3:0]  opc [2];
    logic [31:0] av  [2];
    logic [31:0] bv  [2];
    int          rr;

    alu_arbiter_if #(.VAR_WIDTH(32), .OP_WIDTH(4)) bus ();

    alu_arbiter #(.VAR_WIDTH(32), .OP_WIDTH(4)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return 32'($signed(a) >>> sh);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_grant();
        if (v[rr])     return rr;
        if (v[1 - rr]) return 1 - rr;
        return -1;
    endfunction

    task automatic drive();
        bus.req0_valid  = v[0];
        bus.req0_opcode = opc[0];
        bus.req0_a      = av[0];
        bus.req0_b      = bv[0];
        bus.req1_valid  = v[1];
        bus.req1_opcode = opc[1];
        bus.req1_a      = av[1];
        bus.req1_b      = bv[1];
    endtask

    task automatic post(input int id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        v[id]   = 1'b1;
        opc[id] = op;
        av[id]  = a;
        bv[id]  = b;
    endtask

    // All tasks below start and end 1 time unit after a rising edge;
    // DUT outputs are sampled at the falling edge.
    task automatic idle(input int n);
        drive();
        for (int i = 0; i < n; i++) begin
            #4;
            chk("idle_busy", bus.busy, 0);
            chk("idle_rsp_valid", bus.rsp_valid, 0);
            chk("idle_rdy0", bus.req0_ready, 0);
            chk("idle_rdy1", bus.req1_ready, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_resp(input logic [31:0] e, input int g);
        chk("resp_valid", bus.rsp_valid, 1);
        chk("resp_data", bus.rsp_data, e);
        chk("resp_id", bus.rsp_id, g);
        chk("resp_busy", bus.busy, 1);
        chk("resp_rdy0", bus.req0_ready, 0);
        chk("resp_rdy1", bus.req1_ready, 0);
    endtask

    // one full transaction; stall = RESP cycles with rsp_ready low
    task automatic serve(input int stall);
        int          g;
        logic [31:0] e;
        drive();
        g = exp_grant();
        #4;
        chk("gnt_busy", bus.busy, 0);
        chk("gnt_rsp_valid", bus.rsp_valid, 0);
        chk("gnt_rdy0", bus.req0_ready, g == 0);
        chk("gnt_rdy1", bus.req1_ready, g == 1);
        if (g < 0) begin
            total++;
            bad++;
            $display("FAIL serve_no_request: got none expected a pending request");
            @(posedge clk); #1;
            return;
        end
        e = ref_alu(opc[g], av[g], bv[g]);
        @(posedge clk); #1;
        // winner drops valid and scrambles its fields: result must come from the capture
        v[g]   = 1'b0;
        opc[g] = 4'($urandom);
        av[g]  = $urandom;
        bv[g]  = $urandom;
        drive();
        bus.rsp_ready = (stall == 0);
        #4;
        chk("exec_busy", bus.busy, 1);
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        chk("exec_rdy0", bus.req0_ready, 0);
        chk("exec_rdy1", bus.req1_ready, 0);
        @(posedge clk); #1; #4;
        check_resp(e, g);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            bus.rsp_ready = (s == stall - 1);
            #4;
            check_resp(e, g);
        end
        @(posedge clk); #1;
        rr = 1 - g;
        bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // accept a request, then reset during EXEC (in_resp=0) or during RESP with rsp_ready=1
    task automatic abort(input bit in_resp);
        int g;
        drive();
        g = exp_grant();
        #4;
        chk("abort_rdy0", bus.req0_ready, g == 0);
        chk("abort_rdy1", bus.req1_ready, g == 1);
        @(posedge clk); #1;
        if (g >= 0) v[g] = 1'b0;
        drive();
        bus.rsp_ready = 1'b0;
        if (in_resp) begin
            @(posedge clk); #1;
            bus.rsp_ready = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rr  = 0;
        bus.rsp_ready = 1'b0;
        #4;
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rsp_data", bus.rsp_data, 0);
        chk("abort_rsp_id", bus.rsp_id, 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int r = 0; r < 2; r++) begin
            v[r] = 1'b0; opc[r] = '0; av[r] = '0; bv[r] = '0;
        end
        rr = 0;
        bus.rsp_ready = 1'b0;
        drive();

        // reset values
        repeat (2) @(posedge clk);
        #1; #4;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // single ADD
        bus.rsp_ready = 1'b1;
        post(0, OP_ADD, 32'd5, 32'd7);
        serve(0);

        // both requesting, then both again: rr_ptr returns to req0
        post(0, OP_SUB, 32'd10, 32'd3);
        post(1, OP_XOR, 32'hF0, 32'h0F);
        serve(0);
        serve(0);
        post(0, OP_ADD, 32'd1, 32'd2);
        post(1, OP_ADD, 32'd3, 32'd4);
        serve(0);
        serve(0);

        // wrap-around with backpressure and a competing requester
        post(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        post(1, OP_AND, 32'h1234_5678, 32'h0F0F_0F0F);
        serve(5);
        serve(0);

        // shift masking, signed/unsigned compare, undefined opcode
        post(0, OP_SLL, 32'd1, 32'h21);          serve(0);
        post(1, OP_SRL, 32'h8000_0000, 32'h3F);  serve(1);
        post(0, OP_SRA, 32'h8000_0000, 32'h24);  serve(0);
        post(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);   serve(0);
        post(0, OP_SLTU, 32'hFFFF_FFFF, 32'd1);  serve(2);
        post(1, 4'hF, 32'd3, 32'd4);             serve(0);

        // ready forced low while reset is asserted in IDLE
        post(0, OP_ADD, 32'd8, 32'd8);
        drive();
        rst = 1'b1;
        #4;
        chk("rst_force_rdy0", bus.req0_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        v[0] = 1'b0;
        rr = 0;
        idle(1);

        // reset during EXEC: rr_ptr was 1, must come back as 0
        post(0, OP_ADD, 32'd6, 32'd6);  serve(0);
        post(1, OP_ADD, 32'd9, 32'd9);  abort(0);
        idle(3);
        post(0, OP_OR, 32'hA0, 32'h05);
        post(1, OP_SUB, 32'd0, 32'd1);
        serve(0);
        serve(0);

        // reset during RESP with rsp_ready=1: reset wins, rr_ptr stays 0
        post(0, OP_SUB, 32'd20, 32'd5); abort(1);
        idle(3);
        post(0, OP_XOR, 32'hFF, 32'h0F);
        post(1, OP_ADD, 32'd1, 32'd1);
        serve(0);
        serve(0);

        // random traffic
        for (int it = 0; it < 300; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && $urandom_range(0, 2) != 0)
                    post(r, 4'($urandom_range(0, 15)), rand_val(), rand_val());
            end
            if (!v[0] && !v[1]) idle(1);
            else                serve($urandom_range(0, 3));
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $fatal(1);
    end
endmodule
